// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared types and constants for the ID/EX stage of the 5-stage RISC-V core.
//
//   Contents:
//     XLEN, REG_AW, CTRL_W, CNT_W : default datapath / register / control /
//                                   counter widths
//     hz_state_t                  : hazard sequencer state (RUN, LU_BUBBLE, HOLD)
//     id_ex_t                     : every field held in the ID/EX register
//     ID_EX_BUBBLE                : all-zero register contents (a NOP in EX)
//     sat_inc_cnt                 : saturating increment for the stall counter
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 16;

    // The encoding is visible on the state port, so it is fixed explicitly.
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_BUBBLE = 2'd1,
        HOLD      = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   op2;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
    } id_ex_t;

    // A bubble must not write a register, read memory or match a forwarding
    // source, so every field is zero (data fields included, for determinism).
    localparam id_ex_t ID_EX_BUBBLE = '0;

    // Saturating increment: sticks at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] cnt);
        if (&cnt) begin
            return cnt;
        end
        return cnt + 1'b1;
    endfunction

endpackage : pipe_pkg

// File: rtl/load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
//   Purely combinational load-use hazard comparator. Flags the case where the
//   instruction in EX is a load writing a non-zero register that the valid
//   instruction currently in ID actually reads.
//
//   Ports:
//     ex_valid, ex_mem_read, ex_reg_write : in  control of the instruction in EX
//     ex_rd                               : in  destination of the instruction in EX
//     id_valid                            : in  ID holds a real instruction
//     id_rs1, id_rs2                      : in  ID source register numbers
//     id_use_rs1, id_use_rs2              : in  ID instruction really reads rs1/rs2
//     load_use                            : out hazard detected this cycle
// -----------------------------------------------------------------------------
module load_use_detect
    import pipe_pkg::*;
#(
    parameter int REG_AW = pipe_pkg::REG_AW
) (
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_reg_write,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    output logic              load_use
);

    logic ex_is_load_to_reg;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is hard-wired to zero, so a load targeting it never produces data
    // that a later instruction could depend on.
    assign ex_is_load_to_reg = ex_valid & ex_mem_read & ex_reg_write & (ex_rd != '0);

    // Only sources the instruction really reads count; unused rs fields may
    // hold leftover encoding bits that happen to equal ex_rd.
    assign rs1_hit = id_use_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit = id_use_rs2 & (id_rs2 == ex_rd);

    assign load_use = ex_is_load_to_reg & id_valid & (rs1_hit | rs2_hit);

endmodule : load_use_detect

// File: rtl/id_ex_hazard_stage.sv
// -----------------------------------------------------------------------------
// id_ex_hazard_stage
//   ID/EX pipeline register with load-use hazard detection and stall/flush
//   sequencing. A load followed by a dependent instruction gets exactly one
//   bubble; the forwarding unit (fed by ex_rs1/ex_rs2) covers the rest.
//
//   Pipeline control semantics (one place, read this before binding checkers):
//     - pc_write_en / ifid_write_en are this stage's "ready" towards IF and ID.
//       When low, IF and ID must hold and re-present the same instruction on
//       the next cycle. They are combinational from the current inputs and
//       the current ID/EX contents.
//     - ex_stall is the downstream "not ready": while high (and no flush),
//       ID/EX holds its contents unchanged.
//     - flush overrides everything: ID/EX takes a bubble, IF/ID is flushed
//       (ifid_flush = flush) and fetch continues from the redirected PC.
//     - Priority per cycle: flush > ex_stall > load_use > normal advance.
//
//   Ports:
//     clk, rst_n                          : clock, asynchronous active-low reset
//     id_valid, id_rs1, id_rs2, id_rd     : decoded instruction in ID
//     id_use_rs1, id_use_rs2              : ID instruction really reads rs1/rs2
//     id_reg_write, id_mem_read, id_ctrl  : decoded control
//     id_op1, id_op2, id_imm, id_pc       : decoded operands
//     flush                               : taken branch/jump resolved in EX
//     ex_stall                            : downstream not ready
//     ex_*                                : registered ID/EX contents
//     pc_write_en, ifid_write_en          : front-end write enables (comb)
//     ifid_flush                          : IF/ID flush (comb, equals flush)
//     state                               : action taken at the previous edge
//     stall_count                         : saturating count of stall cycles
//
//   The parameters exist for port-width readability; the register struct is
//   sized by pipe_pkg, so any override must match the package values.
// -----------------------------------------------------------------------------
module id_ex_hazard_stage
    import pipe_pkg::*;
#(
    parameter int XLEN   = pipe_pkg::XLEN,
    parameter int REG_AW = pipe_pkg::REG_AW,
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int CNT_W  = pipe_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [XLEN-1:0]   id_op1,
    input  logic [XLEN-1:0]   id_op2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [XLEN-1:0]   id_pc,

    input  logic              flush,
    input  logic              ex_stall,

    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [XLEN-1:0]   ex_op1,
    output logic [XLEN-1:0]   ex_op2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_pc,

    output logic              pc_write_en,
    output logic              ifid_write_en,
    output logic              ifid_flush,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  stall_count
);

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    id_ex_t           id_ex_q;
    id_ex_t           id_ex_d;
    id_ex_t           id_fields;
    hz_state_t        state_q;
    hz_state_t        state_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    logic             load_use;
    logic             stall_cycle;

    // -------------------------------------------------------------------------
    // Hazard detection against the instruction currently in EX
    // -------------------------------------------------------------------------
    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .ex_valid     (id_ex_q.valid),
        .ex_mem_read  (id_ex_q.mem_read),
        .ex_reg_write (id_ex_q.reg_write),
        .ex_rd        (id_ex_q.rd),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .load_use     (load_use)
    );

    // -------------------------------------------------------------------------
    // Incoming ID fields gathered into the register layout
    // -------------------------------------------------------------------------
    always_comb begin
        id_fields           = ID_EX_BUBBLE;
        id_fields.valid     = id_valid;
        id_fields.reg_write = id_reg_write;
        id_fields.mem_read  = id_mem_read;
        id_fields.rs1       = id_rs1;
        id_fields.rs2       = id_rs2;
        id_fields.rd        = id_rd;
        id_fields.ctrl      = id_ctrl;
        id_fields.op1       = id_op1;
        id_fields.op2       = id_op2;
        id_fields.imm       = id_imm;
        id_fields.pc        = id_pc;
    end

    // -------------------------------------------------------------------------
    // Sequencer: next state, next ID/EX contents and front-end enables
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = RUN;
        id_ex_d       = id_ex_q;
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;

        if (flush) begin
            // The instruction in ID is on the wrong path; squash it even when
            // downstream is stalled, since the redirect must win.
            id_ex_d = ID_EX_BUBBLE;
            state_d = RUN;
        end else if (ex_stall) begin
            id_ex_d       = id_ex_q;
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            state_d       = HOLD;
        end else if (load_use) begin
            // Insert one bubble; ID re-presents the dependent instruction and
            // next cycle the load is in MEM where forwarding can reach it.
            id_ex_d       = ID_EX_BUBBLE;
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            state_d       = LU_BUBBLE;
        end else begin
            id_ex_d = id_fields;
            state_d = RUN;
        end
    end

    assign ifid_flush = flush;

    // Counted only when the front end is actually held back by this stage.
    assign stall_cycle = ~flush & (ex_stall | load_use);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_cycle) begin
            stall_cnt_d = sat_inc_cnt(stall_cnt_q);
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_q <= ID_EX_BUBBLE;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign ex_valid     = id_ex_q.valid;
    assign ex_reg_write = id_ex_q.reg_write;
    assign ex_mem_read  = id_ex_q.mem_read;
    assign ex_rs1       = id_ex_q.rs1;
    assign ex_rs2       = id_ex_q.rs2;
    assign ex_rd        = id_ex_q.rd;
    assign ex_ctrl      = id_ex_q.ctrl;
    assign ex_op1       = id_ex_q.op1;
    assign ex_op2       = id_ex_q.op2;
    assign ex_imm       = id_ex_q.imm;
    assign ex_pc        = id_ex_q.pc;

    assign state        = state_q;
    assign stall_count  = stall_cnt_q;

endmodule : id_ex_hazard_stage

// File: tb/tb_id_ex_hazard_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_hazard_stage
//   Directed and randomized checks of the ID/EX hazard stage against an
//   instruction-level reference model: the model tracks which instruction sits
//   in EX, the last action taken and the stall count, and the driver behaves
//   like IF/ID (re-presenting an instruction whenever the model says the
//   front end was held).
// -----------------------------------------------------------------------------
module tb_id_ex_hazard_stage;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 16;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        use1;
        logic        use2;
        logic        rw;
        logic        mr;
        logic [7:0]  ctrl;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [31:0] pc;
    } instr_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic              id_valid = 1'b0;
    logic [REG_AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic              id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic              id_reg_write = 1'b0, id_mem_read = 1'b0;
    logic [CTRL_W-1:0] id_ctrl = '0;
    logic [XLEN-1:0]   id_op1 = '0, id_op2 = '0, id_imm = '0, id_pc = '0;
    logic              flush = 1'b0, ex_stall = 1'b0;

    logic              ex_valid, ex_reg_write, ex_mem_read;
    logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [XLEN-1:0]   ex_op1, ex_op2, ex_imm, ex_pc;
    logic              pc_write_en, ifid_write_en, ifid_flush;
    logic [1:0]        state;
    logic [CNT_W-1:0]  stall_count;

    id_ex_hazard_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .id_ctrl      (id_ctrl),
        .id_op1       (id_op1),
        .id_op2       (id_op2),
        .id_imm       (id_imm),
        .id_pc        (id_pc),
        .flush        (flush),
        .ex_stall     (ex_stall),
        .ex_valid     (ex_valid),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_ctrl      (ex_ctrl),
        .ex_op1       (ex_op1),
        .ex_op2       (ex_op2),
        .ex_imm       (ex_imm),
        .ex_pc        (ex_pc),
        .pc_write_en  (pc_write_en),
        .ifid_write_en(ifid_write_en),
        .ifid_flush   (ifid_flush),
        .state        (state),
        .stall_count  (stall_count)
    );

    // ---------------- reference model ----------------
    int     checks = 0;
    int     errors = 0;
    instr_t m_ex   = '0;   // instruction occupying EX ('0 = bubble)
    int     m_state = 0;   // 0 advanced/flushed, 1 load-use bubble, 2 held
    int     m_cnt   = 0;
    bit     m_en    = 1'b1; // front end allowed to advance this cycle

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_add(input int a, input int n);
        return (a + n > 65535) ? 65535 : a + n;
    endfunction

    function automatic instr_t mk(input bit v, input int r1, input int r2, input int rd,
                                  input bit u1, input bit u2, input bit rw, input bit mr);
        instr_t i;
        i.valid = v;
        i.rs1 = 5'(r1); i.rs2 = 5'(r2); i.rd = 5'(rd);
        i.use1 = u1; i.use2 = u2; i.rw = rw; i.mr = mr;
        i.ctrl = 8'($urandom);
        i.op1 = $urandom; i.op2 = $urandom; i.imm = $urandom; i.pc = $urandom;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        return mk($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
    endfunction

    task automatic drive(input instr_t i);
        id_valid = i.valid; id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd;
        id_use_rs1 = i.use1; id_use_rs2 = i.use2;
        id_reg_write = i.rw; id_mem_read = i.mr; id_ctrl = i.ctrl;
        id_op1 = i.op1; id_op2 = i.op2; id_imm = i.imm; id_pc = i.pc;
    endtask

    task automatic check_regs();
        check("ex_ctl", {ex_valid, ex_reg_write, ex_mem_read, ex_rs1, ex_rs2, ex_rd, ex_ctrl},
              {m_ex.valid, m_ex.rw, m_ex.mr, m_ex.rs1, m_ex.rs2, m_ex.rd, m_ex.ctrl});
        check("ex_ops", {ex_op1, ex_op2}, {m_ex.op1, m_ex.op2});
        check("ex_imm_pc", {ex_imm, ex_pc}, {m_ex.imm, m_ex.pc});
        check("state", state, m_state[1:0]);
        check("stall_count", stall_count, m_cnt[15:0]);
    endtask

    // One pipeline cycle: present ID/flush/stall, check the front-end
    // enables before the edge, then check the registered results after it.
    task automatic step(input instr_t id, input bit fl, input bit st);
        bit hz;
        @(negedge clk);
        drive(id);
        flush = fl;
        ex_stall = st;
        #1;
        hz = m_ex.valid && m_ex.mr && m_ex.rw && (m_ex.rd != 0) && id.valid &&
             ((id.use1 && id.rs1 == m_ex.rd) || (id.use2 && id.rs2 == m_ex.rd));
        m_en = fl || (!st && !hz);
        check("pc_write_en", pc_write_en, m_en);
        check("ifid_write_en", ifid_write_en, m_en);
        check("ifid_flush", ifid_flush, fl);
        if (fl) begin
            m_ex = '0; m_state = 0;
        end else if (st) begin
            m_state = 2; m_cnt = sat_add(m_cnt, 1);
        end else if (hz) begin
            m_ex = '0; m_state = 1; m_cnt = sat_add(m_cnt, 1);
        end else begin
            m_ex = id; m_state = 0;
        end
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic model_reset();
        m_ex = '0; m_state = 0; m_cnt = 0; m_en = 1'b1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        instr_t lw5, lw0, add, rd0, nouse, inval, cur;
        int     c0;

        // Power-on reset
        #3;
        model_reset();
        check_regs();
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use: lw x5 then add x6,x5,x7 -> one bubble, then add enters EX
        lw5 = mk(1, 1, 0, 5, 1, 0, 1, 1);
        add = mk(1, 5, 7, 6, 1, 1, 1, 0);
        step(lw5, 0, 0);
        step(add, 0, 0);
        check("lu_state_bubble", state, 2'd1);
        check("lu_ex_valid", ex_valid, 1'b0);
        step(add, 0, 0);
        check("lu_ex_rs1", ex_rs1, 5'd5);
        check("lu_state_run", state, 2'd0);
        check("lu_count", stall_count, 16'd1);

        // No false stalls: load to x0, unused rs2 match, invalid ID
        lw0 = mk(1, 1, 0, 0, 1, 0, 1, 1);
        rd0 = mk(1, 0, 0, 8, 1, 1, 1, 0);
        step(lw0, 0, 0);
        step(rd0, 0, 0);
        check("x0_no_stall", {state, ex_rd}, {2'd0, 5'd8});
        nouse = mk(1, 3, 5, 9, 1, 0, 1, 0);
        step(lw5, 0, 0);
        step(nouse, 0, 0);
        check("unused_rs2_no_stall", {state, ex_rd}, {2'd0, 5'd9});
        inval = mk(0, 5, 5, 10, 1, 1, 1, 0);
        step(lw5, 0, 0);
        step(inval, 0, 0);
        check("invalid_id_no_stall", state, 2'd0);
        check("no_stall_count", stall_count, 16'd1);

        // Downstream stall for 3 cycles with add in EX
        step(add, 0, 0);
        c0 = m_cnt;
        cur = rand_instr();
        for (int k = 0; k < 3; k++) begin
            step(cur, 0, 1);
            check("hold_ex_rd", ex_rd, 5'd6);
            check("hold_state", state, 2'd2);
        end
        check("hold_count", stall_count, 16'(c0 + 3));
        step(cur, 0, 0);

        // Flush beats stall and load-use
        step(lw5, 0, 0);
        c0 = m_cnt;
        step(add, 1, 1);
        check("flush_state", state, 2'd0);
        check("flush_bubble", {ex_valid, ex_rd}, 6'd0);
        check("flush_count", stall_count, 16'(c0));

        // Asynchronous reset mid-cycle with a valid instruction in EX
        step(add, 0, 0);
        check("pre_reset_valid", ex_valid, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic; the driver re-presents ID whenever it was held
        cur = rand_instr();
        for (int k = 0; k < 400; k++) begin
            step(cur, $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
            if (m_en) cur = rand_instr();
        end

        // Saturation: 65534 stall cycles, then 3 more
        pulse_reset();
        flush = 1'b0;
        ex_stall = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        m_cnt = sat_add(m_cnt, 65534);
        m_state = 2;
        check("sat_preload", stall_count, 16'hFFFE);
        for (int k = 0; k < 3; k++) begin
            step(cur, 0, 1);
        end
        check("sat_no_wrap", stall_count, 16'hFFFF);

        // Only reset clears the counter
        pulse_reset();
        check("count_cleared", stall_count, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_id_ex_hazard_stage
